// File: rtl/bus_watch_unit_pkg.sv
// Types and helpers shared by the bus watchpoint unit.
`include "watch_defs.vh"

package bus_watch_unit_pkg;

    typedef enum logic [1:0] {
        ModeOff = `MODE_OFF,
        ModeRd  = `MODE_RD,
        ModeWr  = `MODE_WR,
        ModeAny = `MODE_ANY
    } mode_e;

    // Channel index width, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/watch_defs.vh
// Shared bus-watch encodings: channel mode values and trace word field offsets.
// A trace word is {rw, ch, data, addr}, addr at bit 0.
`ifndef WATCH_DEFS_VH
`define WATCH_DEFS_VH

`define MODE_OFF 2'b00
`define MODE_RD  2'b01
`define MODE_WR  2'b10
`define MODE_ANY 2'b11

`define TRACE_ADDR_LSB 0
`define TRACE_DATA_LSB(aw) (aw)
`define TRACE_CH_LSB(aw, dw) ((aw) + (dw))
`define TRACE_RW_BIT(aw, dw, iw) ((aw) + (dw) + (iw))

`endif

// File: rtl/watch_fifo.sv
// First-word-fall-through register FIFO; head is visible whenever empty_o is low.
module watch_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             pop_en, push_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_en  = pop_i && !empty_o;
    // A pop frees the slot this cycle, so a push into a full FIFO is still accepted.
    assign push_en = push_i && (!full_o || pop_en);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_i;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_watch_unit.sv
// Multi-channel 6502 bus watchpoint: per-channel address/mask/mode compare, saturating
// hit counters, sticky threshold halt request and a trace FIFO of matching cycles.
`include "watch_defs.vh"

module bus_watch_unit
    import bus_watch_unit_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned IDX_W   = idx_width(NUM_CH),
    localparam int unsigned TRACE_W = 1 + IDX_W + DATA_W + ADDR_W
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      sample_i,
    input  logic [ADDR_W-1:0]         addr_i,
    input  logic [DATA_W-1:0]         data_i,
    input  logic                      rw_i,
    input  logic [NUM_CH*ADDR_W-1:0]  match_addr_i,
    input  logic [NUM_CH*ADDR_W-1:0]  match_mask_i,
    input  logic [NUM_CH*2-1:0]       match_mode_i,
    input  logic [NUM_CH*CNT_W-1:0]   threshold_i,
    input  logic                      count_clr_i,
    input  logic                      halt_clr_i,
    output logic [NUM_CH-1:0]         hit_o,
    output logic [NUM_CH*CNT_W-1:0]   count_o,
    output logic                      halt_req_o,
    output logic [IDX_W-1:0]          halt_ch_o,
    output logic                      trace_valid_o,
    output logic [TRACE_W-1:0]        trace_data_o,
    input  logic                      trace_pop_i,
    output logic                      trace_ovf_o
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [NUM_CH-1:0]  match, trig;
    logic [NUM_CH-1:0]  hit_q;
    logic               halt_q, halt_d;
    logic [IDX_W-1:0]   halt_ch_q, halt_ch_d;
    logic               ovf_q, ovf_d;
    logic [IDX_W-1:0]   match_idx, trig_idx;
    logic [TRACE_W-1:0] entry;
    logic               push, pop_eff, fifo_full, fifo_empty;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ADDR_W-1:0] ch_addr, ch_mask;
        logic [1:0]        ch_mode;
        logic [CNT_W-1:0]  ch_thr, cnt_q, cnt_d;
        logic              mode_ok, sat;

        assign ch_addr = match_addr_i[c*ADDR_W +: ADDR_W];
        assign ch_mask = match_mask_i[c*ADDR_W +: ADDR_W];
        assign ch_mode = match_mode_i[c*2 +: 2];
        assign ch_thr  = threshold_i[c*CNT_W +: CNT_W];

        assign mode_ok = (ch_mode == ModeAny) || (ch_mode == ModeRd && rw_i)
                      || (ch_mode == ModeWr && !rw_i);
        assign match[c] = sample_i && (ch_mode != ModeOff) && mode_ok
                       && (((addr_i ^ ch_addr) & ~ch_mask) == '0);
        assign sat = (cnt_q == CntMax);

        always_comb begin
            cnt_d = cnt_q;
            if (count_clr_i) begin
                cnt_d = '0;
            end else if (match[c] && !sat) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Only a real increment can trigger, so a saturated counter stays quiet.
        assign trig[c] = match[c] && !count_clr_i && !sat && (ch_thr != '0) && (cnt_d == ch_thr);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign count_o[c*CNT_W +: CNT_W] = cnt_q;
    end

    always_comb begin
        match_idx = '0;
        trig_idx  = '0;
        for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
            if (match[c]) begin
                match_idx = IDX_W'(c);
            end
            if (trig[c]) begin
                trig_idx = IDX_W'(c);
            end
        end
    end

    always_comb begin
        halt_d    = halt_q;
        halt_ch_d = halt_ch_q;
        if (|trig) begin
            halt_d    = 1'b1;
            halt_ch_d = trig_idx;
        end else if (halt_clr_i) begin
            halt_d = 1'b0;
        end
    end

    assign push    = |match;
    assign pop_eff = trace_pop_i && !fifo_empty;

    always_comb begin
        entry = '0;
        entry[`TRACE_ADDR_LSB +: ADDR_W]               = addr_i;
        entry[`TRACE_DATA_LSB(ADDR_W) +: DATA_W]       = data_i;
        entry[`TRACE_CH_LSB(ADDR_W, DATA_W) +: IDX_W]  = match_idx;
        entry[`TRACE_RW_BIT(ADDR_W, DATA_W, IDX_W)]    = rw_i;
    end

    always_comb begin
        ovf_d = ovf_q;
        if (push && fifo_full && !pop_eff) begin
            ovf_d = 1'b1;
        end
        if (count_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_q     <= '0;
            halt_q    <= 1'b0;
            halt_ch_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            hit_q     <= match;
            halt_q    <= halt_d;
            halt_ch_q <= halt_ch_d;
            ovf_q     <= ovf_d;
        end
    end

    watch_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (entry),
        .pop_i   (trace_pop_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_o  (trace_data_o)
    );

    assign hit_o         = hit_q;
    assign halt_req_o    = halt_q;
    assign halt_ch_o     = halt_ch_q;
    assign trace_valid_o = !fifo_empty;
    assign trace_ovf_o   = ovf_q;

endmodule

// File: tb/tb_bus_watch_unit.sv
// Self-checking bench for bus_watch_unit: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model.
module tb_bus_watch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample = 1'b0, rw = 1'b0, count_clr = 1'b0, halt_clr = 1'b0, trace_pop = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  data = '0;

    logic [15:0] cfg_addr [4];
    logic [15:0] cfg_mask [4];
    logic [1:0]  cfg_mode [4];
    logic [7:0]  cfg_thr  [4];
    logic [63:0] match_addr_v, match_mask_v;
    logic [7:0]  match_mode_v;
    logic [31:0] threshold_v;

    logic [3:0]  hit;
    logic [31:0] count;
    logic        halt_req, trace_valid, trace_ovf;
    logic [1:0]  halt_ch;
    logic [26:0] trace_data;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int          m_cnt [4];
    bit          m_halt;
    int          m_halt_ch;
    logic [3:0]  m_hit;
    logic [26:0] m_q [$];
    bit          m_ovf;

    always #5 clk = ~clk;

    always_comb begin
        match_addr_v = '0;
        match_mask_v = '0;
        match_mode_v = '0;
        threshold_v  = '0;
        for (int c = 0; c < 4; c++) begin
            match_addr_v[c*16 +: 16] = cfg_addr[c];
            match_mask_v[c*16 +: 16] = cfg_mask[c];
            match_mode_v[c*2 +: 2]   = cfg_mode[c];
            threshold_v[c*8 +: 8]    = cfg_thr[c];
        end
    end

    bus_watch_unit #(
        .NUM_CH (4),
        .ADDR_W (16),
        .DATA_W (8),
        .CNT_W  (8),
        .DEPTH  (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .sample_i      (sample),
        .addr_i        (addr),
        .data_i        (data),
        .rw_i          (rw),
        .match_addr_i  (match_addr_v),
        .match_mask_i  (match_mask_v),
        .match_mode_i  (match_mode_v),
        .threshold_i   (threshold_v),
        .count_clr_i   (count_clr),
        .halt_clr_i    (halt_clr),
        .hit_o         (hit),
        .count_o       (count),
        .halt_req_o    (halt_req),
        .halt_ch_o     (halt_ch),
        .trace_valid_o (trace_valid),
        .trace_data_o  (trace_data),
        .trace_pop_i   (trace_pop),
        .trace_ovf_o   (trace_ovf)
    );

    function automatic logic [31:0] model_counts();
        logic [31:0] v;
        for (int c = 0; c < 4; c++) v[c*8 +: 8] = 8'(m_cnt[c]);
        return v;
    endfunction

    // One clock of the reference behaviour, applied to the inputs currently driven.
    task automatic model_step();
        logic [3:0] mv;
        int first;
        int trig_ch;
        mv = '0;
        for (int c = 0; c < 4; c++) begin
            if (sample && cfg_mode[c] != 2'b00 && ((addr ^ cfg_addr[c]) & ~cfg_mask[c]) == 16'h0
                && (cfg_mode[c] == 2'b11 || (cfg_mode[c] == 2'b01 && rw)
                    || (cfg_mode[c] == 2'b10 && !rw)))
                mv[c] = 1'b1;
        end
        trig_ch = -1;
        for (int c = 0; c < 4; c++) begin
            if (count_clr) begin
                m_cnt[c] = 0;
            end else if (mv[c] && m_cnt[c] < 255) begin
                m_cnt[c]++;
                if (cfg_thr[c] != 0 && m_cnt[c] == int'(cfg_thr[c]) && trig_ch < 0) trig_ch = c;
            end
        end
        if (trig_ch >= 0) begin
            m_halt = 1'b1;
            m_halt_ch = trig_ch;
        end else if (halt_clr) begin
            m_halt = 1'b0;
        end
        if (trace_pop && m_q.size() > 0) void'(m_q.pop_front());
        if (mv != 0) begin
            first = -1;
            for (int c = 0; c < 4; c++) if (mv[c] && first < 0) first = c;
            if (m_q.size() < 16) m_q.push_back({rw, 2'(first), data, addr});
            else m_ovf = 1'b1;
        end
        if (count_clr) m_ovf = 1'b0;
        m_hit = mv;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        sample = 1'b0;
        count_clr = 1'b0;
        halt_clr = 1'b0;
        trace_pop = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample = 1'b0; count_clr = 1'b0; halt_clr = 1'b0; trace_pop = 1'b0;
        addr = '0; data = '0; rw = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cfg_addr[c] = '0; cfg_mask[c] = '0; cfg_mode[c] = 2'b00; cfg_thr[c] = '0;
            m_cnt[c] = 0;
        end
        m_halt = 1'b0; m_halt_ch = 0; m_hit = '0; m_ovf = 1'b0;
        m_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks += 7;
        if (hit !== 4'h0) begin n_errors++; $display("FAIL reset_hit: got %h expected 0", hit); end
        if (count !== 32'h0) begin n_errors++; $display("FAIL reset_count: got %h expected 0", count); end
        if (halt_req !== 1'b0) begin n_errors++; $display("FAIL reset_halt: got %b expected 0", halt_req); end
        if (halt_ch !== 2'd0) begin n_errors++; $display("FAIL reset_halt_ch: got %0d expected 0", halt_ch); end
        if (trace_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", trace_valid); end
        if (trace_data !== 27'h0) begin n_errors++; $display("FAIL reset_tdata: got %h expected 0", trace_data); end
        if (trace_ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b expected 0", trace_ovf); end
    endtask

    task automatic test_addr_match();
        do_reset();
        cfg_addr[0] = 16'hFD10; cfg_mask[0] = 16'h0000; cfg_mode[0] = 2'b11;
        sample = 1'b1; addr = 16'hFD10; rw = 1'b1; data = 8'h5A;
        tick();
        n_checks += 4;
        if (hit !== 4'b0001) begin n_errors++; $display("FAIL exact_hit: got %b expected 0001", hit); end
        if (count[7:0] !== 8'd1) begin n_errors++; $display("FAIL exact_count0: got %0d expected 1", count[7:0]); end
        if (trace_valid !== 1'b1) begin n_errors++; $display("FAIL exact_valid: got %b expected 1", trace_valid); end
        if (trace_data !== {1'b1, 2'd0, 8'h5A, 16'hFD10})
            begin n_errors++; $display("FAIL exact_entry: got %h expected %h", trace_data, {1'b1, 2'd0, 8'h5A, 16'hFD10}); end
        sample = 1'b1; addr = 16'hFD11; rw = 1'b1; data = 8'h11;
        tick();
        n_checks += 2;
        if (hit !== 4'b0000) begin n_errors++; $display("FAIL exact_miss_hit: got %b expected 0000", hit); end
        if (count[7:0] !== 8'd1) begin n_errors++; $display("FAIL exact_miss_count: got %0d expected 1", count[7:0]); end
    endtask

    task automatic test_mask_mode();
        do_reset();
        cfg_addr[1] = 16'h0200; cfg_mask[1] = 16'h000F; cfg_mode[1] = 2'b10;
        sample = 1'b1; addr = 16'h020A; rw = 1'b0; data = 8'h33;
        tick();
        n_checks++;
        if (hit !== 4'b0010) begin n_errors++; $display("FAIL mask_write_hit: got %b expected 0010", hit); end
        sample = 1'b1; addr = 16'h0205; rw = 1'b1; data = 8'h44;
        tick();
        n_checks += 2;
        if (hit !== 4'b0000) begin n_errors++; $display("FAIL mask_read_hit: got %b expected 0000", hit); end
        if (count[15:8] !== 8'd1) begin n_errors++; $display("FAIL mask_count1: got %0d expected 1", count[15:8]); end
    endtask

    task automatic test_threshold();
        do_reset();
        cfg_addr[2] = 16'h0300; cfg_mode[2] = 2'b11; cfg_thr[2] = 8'd3;
        for (int i = 0; i < 3; i++) begin
            sample = 1'b1; addr = 16'h0300; rw = 1'(i); data = 8'(i);
            tick();
            n_checks++;
            if (halt_req !== (i == 2))
                begin n_errors++; $display("FAIL thr_halt_%0d: got %b expected %b", i, halt_req, (i == 2)); end
        end
        n_checks++;
        if (halt_ch !== 2'd2) begin n_errors++; $display("FAIL thr_halt_ch: got %0d expected 2", halt_ch); end
        halt_clr = 1'b1; sample = 1'b1; addr = 16'h0300;
        tick();
        n_checks += 2;
        if (halt_req !== 1'b0) begin n_errors++; $display("FAIL thr_clr_halt: got %b expected 0", halt_req); end
        if (count[23:16] !== 8'd4) begin n_errors++; $display("FAIL thr_count2: got %0d expected 4", count[23:16]); end
    endtask

    task automatic test_saturation();
        do_reset();
        cfg_addr[0] = 16'h4000; cfg_mode[0] = 2'b11; cfg_thr[0] = 8'd255;
        for (int i = 0; i < 300; i++) begin
            sample = 1'b1; addr = 16'h4000; rw = 1'b1; data = 8'(i);
            trace_pop = 1'b1;
            if (i == 255) halt_clr = 1'b1;
            tick();
            if (i == 254 || i == 255) begin
                n_checks++;
                if (halt_req !== (i == 254))
                    begin n_errors++; $display("FAIL sat_halt_%0d: got %b expected %b", i, halt_req, (i == 254)); end
            end
        end
        n_checks += 2;
        if (count[7:0] !== 8'hFF) begin n_errors++; $display("FAIL sat_count: got %h expected ff", count[7:0]); end
        if (halt_req !== 1'b0) begin n_errors++; $display("FAIL sat_retrigger: got %b expected 0", halt_req); end
        count_clr = 1'b1; sample = 1'b1; addr = 16'h4000;
        tick();
        n_checks += 2;
        if (count[7:0] !== 8'h00) begin n_errors++; $display("FAIL sat_clr_count: got %h expected 00", count[7:0]); end
        if (hit !== 4'b0001) begin n_errors++; $display("FAIL sat_clr_hit: got %b expected 0001", hit); end
    endtask

    task automatic test_overflow();
        int pops;
        do_reset();
        cfg_mask[0] = 16'hFFFF; cfg_mode[0] = 2'b11;
        for (int i = 0; i < 17; i++) begin
            sample = 1'b1; addr = 16'(i); data = 8'(i); rw = 1'b1;
            tick();
        end
        n_checks += 2;
        if (trace_valid !== 1'b1) begin n_errors++; $display("FAIL ovf_valid: got %b expected 1", trace_valid); end
        if (trace_ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %b expected 1", trace_ovf); end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (trace_data !== {1'b1, 2'd0, 8'(i), 16'(i)})
                begin n_errors++; $display("FAIL ovf_order_%0d: got %h expected %h", i, trace_data, {1'b1, 2'd0, 8'(i), 16'(i)}); end
            trace_pop = 1'b1;
            tick();
        end
        n_checks += 2;
        if (trace_valid !== 1'b0) begin n_errors++; $display("FAIL ovf_drained: got %b expected 0", trace_valid); end
        if (trace_ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %b expected 1", trace_ovf); end
        count_clr = 1'b1;
        tick();
        n_checks++;
        if (trace_ovf !== 1'b0) begin n_errors++; $display("FAIL ovf_clr: got %b expected 0", trace_ovf); end
        for (int i = 0; i < 16; i++) begin
            sample = 1'b1; addr = 16'h8000 + 16'(i); data = 8'($urandom); rw = 1'($urandom);
            tick();
        end
        sample = 1'b1; addr = 16'h9999; data = 8'hA5; rw = 1'b0; trace_pop = 1'b1;
        tick();
        n_checks += 2;
        if (trace_ovf !== 1'b0) begin n_errors++; $display("FAIL ovf_poppush: got %b expected 0", trace_ovf); end
        if (trace_data !== m_q[0]) begin n_errors++; $display("FAIL ovf_poppush_head: got %h expected %h", trace_data, m_q[0]); end
        pops = 0;
        for (int i = 0; i < 20 && trace_valid; i++) begin
            n_checks++;
            if (trace_data !== m_q[0]) begin n_errors++; $display("FAIL ovf_drain_%0d: got %h expected %h", i, trace_data, m_q[0]); end
            trace_pop = 1'b1;
            tick();
            pops++;
        end
        n_checks++;
        if (pops != 16) begin n_errors++; $display("FAIL ovf_entries: got %0d expected 16", pops); end
    endtask

    task automatic test_multi_match();
        do_reset();
        cfg_addr[0] = 16'h1234; cfg_mode[0] = 2'b11;
        cfg_addr[3] = 16'h1200; cfg_mask[3] = 16'h00FF; cfg_mode[3] = 2'b11;
        sample = 1'b1; addr = 16'h1234; data = 8'h77; rw = 1'b0;
        tick();
        n_checks += 3;
        if (hit !== 4'b1001) begin n_errors++; $display("FAIL multi_hit: got %b expected 1001", hit); end
        if (trace_data !== {1'b0, 2'd0, 8'h77, 16'h1234})
            begin n_errors++; $display("FAIL multi_entry: got %h expected %h", trace_data, {1'b0, 2'd0, 8'h77, 16'h1234}); end
        if (count !== 32'h0100_0001) begin n_errors++; $display("FAIL multi_count: got %h expected 01000001", count); end
        trace_pop = 1'b1;
        tick();
        n_checks++;
        if (trace_valid !== 1'b0) begin n_errors++; $display("FAIL multi_single: got %b expected 0", trace_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cfg_mask[0] = 16'hFFFF; cfg_mode[0] = 2'b11; cfg_thr[0] = 8'd3;
        for (int i = 0; i < 5; i++) begin
            sample = 1'b1; addr = 16'($urandom); data = 8'($urandom); rw = 1'b1;
            tick();
        end
        n_checks++;
        if (halt_req !== 1'b1) begin n_errors++; $display("FAIL mid_pre_halt: got %b expected 1", halt_req); end
        sample = 1'b1;
        #2 rst = 1'b1;
        #1;
        n_checks += 6;
        if (hit !== 4'h0) begin n_errors++; $display("FAIL mid_hit: got %b expected 0", hit); end
        if (count !== 32'h0) begin n_errors++; $display("FAIL mid_count: got %h expected 0", count); end
        if (halt_req !== 1'b0) begin n_errors++; $display("FAIL mid_halt: got %b expected 0", halt_req); end
        if (trace_valid !== 1'b0) begin n_errors++; $display("FAIL mid_valid: got %b expected 0", trace_valid); end
        if (trace_data !== 27'h0) begin n_errors++; $display("FAIL mid_tdata: got %h expected 0", trace_data); end
        if (trace_ovf !== 1'b0) begin n_errors++; $display("FAIL mid_ovf: got %b expected 0", trace_ovf); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                for (int c = 0; c < 4; c++) begin
                    cfg_mode[c] = 2'($urandom_range(0, 3));
                    cfg_addr[c] = 16'h1000 | 16'($urandom_range(0, 31));
                    cfg_mask[c] = 16'($urandom_range(0, 7));
                    cfg_thr[c]  = 8'($urandom_range(0, 6));
                end
            end
            sample    = ($urandom_range(0, 3) != 0);
            addr      = 16'h1000 | 16'($urandom_range(0, 31));
            data      = 8'($urandom);
            rw        = 1'($urandom);
            trace_pop = ($urandom_range(0, 2) == 0);
            count_clr = ($urandom_range(0, 39) == 0);
            halt_clr  = ($urandom_range(0, 7) == 0);
            tick();
            n_checks += 6;
            if (hit !== m_hit) begin n_errors++; $display("FAIL rnd_hit@%0d: got %b expected %b", i, hit, m_hit); end
            if (count !== model_counts())
                begin n_errors++; $display("FAIL rnd_count@%0d: got %h expected %h", i, count, model_counts()); end
            if (halt_req !== m_halt) begin n_errors++; $display("FAIL rnd_halt@%0d: got %b expected %b", i, halt_req, m_halt); end
            if (halt_ch !== 2'(m_halt_ch))
                begin n_errors++; $display("FAIL rnd_halt_ch@%0d: got %0d expected %0d", i, halt_ch, m_halt_ch); end
            if (trace_valid !== (m_q.size() > 0))
                begin n_errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", i, trace_valid, (m_q.size() > 0)); end
            if (trace_ovf !== m_ovf) begin n_errors++; $display("FAIL rnd_ovf@%0d: got %b expected %b", i, trace_ovf, m_ovf); end
            if (m_q.size() > 0) begin
                n_checks++;
                if (trace_data !== m_q[0])
                    begin n_errors++; $display("FAIL rnd_tdata@%0d: got %h expected %h", i, trace_data, m_q[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_addr_match();
        test_mask_mode();
        test_threshold();
        test_saturation();
        test_overflow();
        test_multi_match();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_watch_unit.md
# bus_watch_unit

Parametrised multi-channel bus watchpoint for the 6502C debug top: compares every qualified CPU bus cycle against NUM_CH programmable address/mask/mode channels and keeps a saturating hit counter per channel. It raises a sticky halt request when a channel reaches its programmed threshold, and logs matching cycles into a first-word-fall-through trace FIFO. The LCD/ChipScope logic drains that FIFO. It replaces the single fixed-address, DIP-switch hit counter with a configurable, multi-channel, trace-capable unit.

## Interface
- NUM_CH, 4, number of watch channels (1..8)
- ADDR_W, 16, address bus width
- DATA_W, 8, data bus width
- CNT_W, 8, per-channel hit counter width
- DEPTH, 16, trace FIFO entries (power of two, >=2)
- Derived: IDX_W = max(1, clog2(NUM_CH)); TRACE_W = 1 + IDX_W + DATA_W + ADDR_W
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sample  in  1  one-cycle strobe: addr/data/rw hold a valid bus cycle (generated from phi2 edge upstream)
- addr  in  ADDR_W  CPU address
- data  in  DATA_W  CPU data
- rw  in  1  1 = read, 0 = write (6502 polarity)
- match_addr  in  NUM_CH*ADDR_W  per-channel compare address, channel c at [c*ADDR_W +: ADDR_W]
- match_mask  in  NUM_CH*ADDR_W  1 bits = don't care
- match_mode  in  NUM_CH*2  00 off, 01 read, 10 write, 11 any
- threshold  in  NUM_CH*CNT_W  halt threshold; 0 = never halt
- count_clr  in  1  clears all counters and trace_ovf
- halt_clr  in  1  clears halt_req
- hit  out  NUM_CH  one-cycle per-channel match pulse
- count  out  NUM_CH*CNT_W  per-channel hit counts
- halt_req  out  1  sticky halt request (feeds CPU HALT)
- halt_ch  out  IDX_W  lowest channel that caused the latest halt set
- trace_valid  out  1  FIFO non-empty
- trace_data  out  TRACE_W  head entry {rw, ch, data, addr}
- trace_pop  in  1  consume head when trace_valid
- trace_ovf  out  1  sticky: push dropped while full

## Operation
- match[c] = mode!=00 && (((addr ^ match_addr_c) & ~match_mask_c) == 0) && (mode==11 || (mode==01 && rw) || (mode==10 && !rw)); evaluated only when sample=1.
- Counter c: +1 on match, saturates at 2^CNT_W-1 (no wrap). count_clr in the same cycle wins: counter goes to 0, and that hit is not counted.
- Trigger c: threshold_c!=0 and the post-increment count equals threshold_c. A saturated counter never re-triggers. Any trigger sets halt_req and loads halt_ch with the lowest triggering channel. Set beats halt_clr in the same cycle.
- Trace push: sample with any match. Entry = {rw, lowest matching channel, data, addr}. If full and no pop, the entry is dropped and trace_ovf is set. If full and popped in the same cycle, both occur and the count is unchanged. If empty, push alone; a pop is ignored when trace_valid=0.
- count_clr clears trace_ovf only. FIFO contents are untouched.
- Mode change mid-stream takes effect on the next sample. No internal state depends on config.

## Timing
- Reset values: hit=0, count=0, halt_req=0, halt_ch=0, trace_valid=0, trace_ovf=0, FIFO pointers=0, trace_data=0.
- Latency 1: sample at edge N gives hit, count, halt_req and trace_valid updates visible after edge N+1.
- hit is high exactly one cycle per matching sample. Back-to-back samples are supported every cycle.
- FWFT: trace_data is valid the same cycle trace_valid=1. Pop at edge N presents the next entry after edge N.
- halt_req deasserts the cycle after halt_clr, unless a new trigger occurs in that cycle.
- rst asserted mid-operation clears everything immediately (async). Release is synchronous to clk.

## Structure
- Include file watch_defs.vh holds the mode encodings (MODE_OFF/RD/WR/ANY) and the trace field offsets macros.
- Sub-module watch_fifo (parameters WIDTH, DEPTH): FWFT register FIFO with push/pop/full/empty. It is reusable for other debug capture.
- Channels are generated with a generate loop. The priority encoders for lowest match and lowest trigger are plain combinational logic.

## Test plan
- Ch0 addr=FD10, mask=0000, mode=11. Samples at FD10 (read) and FD11 -> hit[0] once; count0=1; trace entry {1,0,data,FD10}.
- Ch1 mask=000F, mode=10, addr=0200. Write to 020A and read of 0205 -> only the write hits; count1=1.
- Ch2 threshold=3. Three matching samples -> halt_req rises after the third, halt_ch=2. halt_clr and a 4th match in the same cycle -> halt_req stays 0 (count 4 != 3).
- CNT_W=8, 300 matches -> count saturates at FF, no wrap, no re-trigger. count_clr with a simultaneous match -> count=0.
- DEPTH=16. Push 17 matches with no pop -> trace_valid=1, trace_ovf=1, the first 16 entries are read back in order. Pop and push while full -> no overflow.
- Ch0 and ch3 both match one sample -> hit=1001, a single trace entry with ch=0. rst mid-burst -> all outputs 0 the same cycle.
